booth_seq_ctrl: RTL and testbench
=================================

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, multiplier operand width; even, >= 4.
REQ-002 Parameter IDX_W, default $clog2(WIDTH/2), width of digit index; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous and active-low.
REQ-005 i_valid  input  1  requester presents a multiplier operand.
REQ-006 o_ready  output  1  controller accepts an operand this cycle.
REQ-007 i_mplr  input  WIDTH  signed multiplier operand, sampled on the accept cycle.
REQ-008 i_flush  input  1  synchronous abort of the current operation.
REQ-009 o_load  output  1  datapath loads the multiplicand and clears the accumulator.
REQ-010 o_step  output  1  datapath adds the selected partial product, then shifts the accumulator 2 places.
REQ-011 o_op  output  3  Booth digit select: [2]=negate, [1]=2M, [0]=1M.
REQ-012 o_idx  output  IDX_W  index of the digit currently applied, 0 = least significant.
REQ-013 o_valid  output  1  datapath result is complete and valid.
REQ-014 i_ready  input  1  consumer takes the result.

Function
REQ-015 FSM states: IDLE, LOAD, STEP, DONE; state and datapath registers are flops; outputs decode from registered state only.
REQ-016 IDLE: o_ready=1; all other outputs 0.
REQ-017 IDLE with i_valid=1 (accept): capture {i_mplr, 1'b0} into a WIDTH+1-bit shift register, clear the index, go to LOAD.
REQ-018 LOAD: o_load=1 for exactly one cycle; next state STEP.
REQ-019 STEP: o_step=1; o_idx=index; o_op is decoded from shift register bits [2:0] (b2i+1, b2i, b2i-1).
REQ-020 Booth decode: 000/111 -> 000 (zero); 001/010 -> 001 (+M); 011 -> 010 (+2M); 100 -> 110 (-2M); 101/110 -> 101 (-M).
REQ-021 Each STEP cycle: arithmetic right shift of the shift register by 2, sign-extending the MSB; index +1.
REQ-022 STEP lasts exactly WIDTH/2 cycles; after the cycle with index = WIDTH/2-1, go to DONE; the index never wraps inside an operation.
REQ-023 DONE: o_valid=1; hold o_valid until i_ready=1; on the cycle with i_ready=1, go to IDLE.
REQ-024 Latency: accept at edge N; o_load high in cycle N+1; o_step high in cycles N+2 .. N+1+WIDTH/2; o_valid first high in cycle N+2+WIDTH/2.
REQ-025 o_ready=0 in LOAD, STEP and DONE; i_valid is ignored there and no operand is captured.
REQ-026 In DONE with i_ready=1 and i_valid=1 in the same cycle: only the result is consumed; the new operand is accepted no earlier than the next IDLE cycle.
REQ-027 i_flush=1 in LOAD, STEP or DONE: go to IDLE next cycle; no o_step after the flush cycle; o_valid is never asserted for the aborted operation.
REQ-028 i_flush has priority over i_ready and over every state transition; i_flush in IDLE blocks acceptance that cycle.
REQ-029 In any state other than STEP: o_op=000 and o_idx=0.

Reset
REQ-030 n_rst=0 forces IDLE immediately, independent of clk; index and shift register clear to 0.
REQ-031 While n_rst=0 and after release: o_ready=1; o_load, o_step, o_valid=0; o_op=000; o_idx=0.
REQ-032 Reset asserted mid-operation discards the operation; no o_valid follows; first acceptance is possible on the first edge after release.

Verification (WIDTH=8)
REQ-033 i_mplr=8'h03 accepted at edge 0 -> o_load in cycle 1; o_op per cycle 2..5 = 101, 001, 000, 000 with o_idx 0..3; o_valid in cycle 6.
REQ-034 i_mplr=8'h80 -> o_op = 000, 000, 000, 110; i_mplr=8'h55 -> o_op = 001 in all four steps; i_mplr=8'hFF -> 101, 000, 000, 000.
REQ-035 i_ready=0 for 3 cycles in DONE with i_valid=1 held -> o_valid stays 1, o_ready stays 0; i_ready=1 -> IDLE next cycle; operand accepted the cycle after.
REQ-036 i_flush=1 during the STEP cycle with o_idx=1 -> IDLE next cycle, o_ready=1, no further o_step, no o_valid.
REQ-037 n_rst pulsed low between clock edges during STEP -> outputs go to their reset values immediately; a new i_mplr=8'h03 after release reproduces the sequence in REQ-033 exactly.
REQ-038 Randomised operands checked against a reference model: sum over i of digit_i * 4^i == signed i_mplr for every completed operation.

Source files
------------

// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if
//   Handshake and control bundle between a multiplier-operand requester,
//   the radix-4 Booth sequencer and its datapath/result consumer.
//   Ports (seen from the sequencer, modport slave):
//     i_valid, i_mplr  - operand offer from the requester
//     o_ready          - sequencer is idle and takes an operand
//     i_flush          - synchronous abort of the running operation
//     o_load           - datapath loads multiplicand, clears accumulator
//     o_step, o_op, o_idx - apply Booth digit o_op at digit position o_idx
//     o_valid, i_ready - result handshake with the consumer
//   modport master is the requester/datapath side of the same bundle.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();
  localparam int IDX_W = $clog2(WIDTH / 2);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_mplr;
  logic             i_flush;
  logic             o_load;
  logic             o_step;
  logic [2:0]       o_op;
  logic [IDX_W-1:0] o_idx;
  logic             o_valid;
  logic             i_ready;

  modport slave (
    input  i_valid, i_mplr, i_flush, i_ready,
    output o_ready, o_load, o_step, o_op, o_idx, o_valid
  );

  modport master (
    output i_valid, i_mplr, i_flush, i_ready,
    input  o_ready, o_load, o_step, o_op, o_idx, o_valid
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
//   Sequencer for a radix-4 Booth multiplier. Accepts a signed multiplier
//   operand, pulses o_load once, then issues WIDTH/2 o_step cycles, each
//   carrying the Booth digit select for one digit position, and finally
//   holds o_valid until the consumer takes the result.
//   Ports:
//     clk   - single clock, rising edge
//     n_rst - asynchronous active-low reset
//     bus   - booth_seq_ctrl_if.slave (handshake, digit select, result)
//
//   state | meaning
//   IDLE  | waiting for an operand, o_ready=1
//   LOAD  | datapath loads multiplicand / clears accumulator
//   STEP  | one Booth digit applied per cycle
//   DONE  | result valid, waiting for i_ready
module booth_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH / 2)
) (
  input  logic            clk,
  input  logic            n_rst,
  booth_seq_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH / 2 - 1);

  logic [1:0]       state;
  // Multiplier with an implicit zero appended below bit 0; bits [2:0]
  // always hold the overlapping triplet for the current digit.
  logic [WIDTH:0]   sreg;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.i_flush && bus.i_valid) begin
            sreg  <= {bus.i_mplr, 1'b0};
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= bus.i_flush ? IDLE : STEP;
        end
        STEP: begin
          if (bus.i_flush) begin
            state <= IDLE;
          end else begin
            sreg <= {sreg[WIDTH], sreg[WIDTH], sreg[WIDTH:2]};
            // Index parks on the last digit instead of wrapping.
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.i_flush || bus.i_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [2:0] booth_decode(input logic [2:0] trip);
    logic [2:0] op;
    case (trip)
      3'b001, 3'b010: op = 3'b001;
      3'b011:         op = 3'b010;
      3'b100:         op = 3'b110;
      3'b101, 3'b110: op = 3'b101;
      default:        op = 3'b000;
    endcase
    return op;
  endfunction

  always_comb begin
    bus.o_ready = (state == IDLE);
    bus.o_load  = (state == LOAD);
    bus.o_step  = (state == STEP);
    bus.o_valid = (state == DONE);
    bus.o_op    = (state == STEP) ? booth_decode(sreg[2:0]) : 3'b000;
    bus.o_idx   = (state == STEP) ? idx : '0;
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;
  localparam int W = 8;
  localparam int H = W / 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  booth_seq_ctrl_if #(.WIDTH(W)) bus ();
  booth_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  logic rnd_mode = 1'b0;
  logic rdy_dir  = 1'b1;
  logic rdy_rnd  = 1'b1;
  assign bus.i_ready = rnd_mode ? rdy_rnd : rdy_dir;
  always @(posedge clk) begin
    #2 rdy_rnd = ($urandom_range(0, 2) != 0);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [2:0] op; int idx; } step_t;
  typedef struct { int c; int val; } res_t;
  int    load_q[$];
  step_t step_q[$];
  res_t  res_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: digit_i = -2*b(2i+1) + b(2i) + b(2i-1), b(-1)=0.
  function automatic logic [2:0] model_op(input logic [W-1:0] m, input int i);
    int d;
    int lo;
    lo = (i == 0) ? 0 : int'(m[2*i-1]);
    d  = -2 * int'(m[2*i+1]) + int'(m[2*i]) + lo;
    case (d)
      1:       return 3'b001;
      2:       return 3'b010;
      -1:      return 3'b101;
      -2:      return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // c = edge count before the accepting edge.
  task automatic push_expect(input logic [W-1:0] m, input int c, input int nsteps,
                             input bit result, input bit use_dir, input logic [3*H-1:0] dir);
    step_t s;
    res_t  r;
    load_q.push_back(c + 1);
    for (int i = 0; i < nsteps; i++) begin
      s.c   = c + 2 + i;
      s.op  = use_dir ? dir[3*i +: 3] : model_op(m, i);
      s.idx = i;
      step_q.push_back(s);
    end
    if (result) begin
      r.c   = c + 2 + H;
      r.val = int'($signed(m));
      res_q.push_back(r);
    end
  endtask

  task automatic issue(input logic [W-1:0] m, input int nsteps, input bit result,
                       input bit use_dir, input logic [3*H-1:0] dir, input bit hold);
    int n = 0;
    while (!bus.o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", bus.o_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_mplr  = m;
    push_expect(m, cyc, nsteps, result, use_dir, dir);
    @(negedge clk);
    if (!hold) bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", bus.o_ready, 1);
  endtask

  task automatic wait_step(input int idx);
    int n = 0;
    @(negedge clk);
    while (!(bus.o_step && bus.o_idx == idx) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("step_wait_timeout", bus.o_step, 1);
  endtask

  function automatic logic [8:0] out_vec();
    return {bus.o_ready, bus.o_load, bus.o_step, bus.o_valid, bus.o_op, bus.o_idx};
  endfunction

  // Monitor / scoreboard
  int  sum = 0;
  bit  prev_valid = 1'b0;
  always @(negedge clk) begin
    int    lc;
    step_t s;
    res_t  r;
    int    mag;
    if (bus.o_load) begin
      if (load_q.size() == 0) check("unexpected_load", 1, 0);
      else begin lc = load_q.pop_front(); check("load_cycle", cyc, lc); end
      sum = 0;
    end
    if (bus.o_step) begin
      if (step_q.size() == 0) check("unexpected_step", 1, 0);
      else begin
        s = step_q.pop_front();
        check("step_cycle", cyc, s.c);
        check("step_op", bus.o_op, s.op);
        check("step_idx", bus.o_idx, s.idx);
      end
      mag = bus.o_op[1] ? 2 : (bus.o_op[0] ? 1 : 0);
      sum += (bus.o_op[2] ? -mag : mag) * (1 << (2 * int'(bus.o_idx)));
    end else begin
      check("op_idx_outside_step", {bus.o_op, bus.o_idx}, 0);
    end
    if (bus.o_valid && !prev_valid) begin
      if (res_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        r = res_q.pop_front();
        check("valid_cycle", cyc, r.c);
        check("result_sum", sum, r.val);
      end
    end
    prev_valid = bus.o_valid;
    if (load_q.size() > 0 && load_q[0] < cyc) begin
      check("missing_load", 0, 1); void'(load_q.pop_front());
    end
    if (step_q.size() > 0 && step_q[0].c < cyc) begin
      check("missing_step", 0, 1); void'(step_q.pop_front());
    end
    if (res_q.size() > 0 && res_q[0].c < cyc) begin
      check("missing_valid", 0, 1); void'(res_q.pop_front());
    end
  end

  localparam logic [8:0]     RST_OUT = 9'b1_0_0_0_000_00;
  localparam logic [3*H-1:0] D03 = 12'b000_000_001_101;
  localparam logic [3*H-1:0] D80 = 12'b110_000_000_000;
  localparam logic [3*H-1:0] D55 = 12'b001_001_001_001;
  localparam logic [3*H-1:0] DFF = 12'b000_000_000_101;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_mplr  = '0;
    bus.i_flush = 1'b0;
    #2 check("reset_outputs", out_vec(), RST_OUT);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", out_vec(), RST_OUT);

    // Directed digit patterns
    issue(8'h03, H, 1, 1, D03, 0); wait_idle();
    issue(8'h80, H, 1, 1, D80, 0); wait_idle();
    issue(8'h55, H, 1, 1, D55, 0); wait_idle();
    issue(8'hFF, H, 1, 1, DFF, 0); wait_idle();

    // Flush in IDLE blocks acceptance
    bus.i_flush = 1'b1; bus.i_valid = 1'b1; bus.i_mplr = 8'h11;
    @(negedge clk);
    check("flush_blocks_accept", out_vec(), RST_OUT);
    bus.i_flush = 1'b0; bus.i_valid = 1'b0;

    // Result stall with a new operand held on i_valid
    rdy_dir = 1'b0;
    issue(8'h5A, H, 1, 0, '0, 1);
    bus.i_mplr = 8'hC3;
    begin
      int n = 0;
      while (!bus.o_valid && n < 20) begin @(negedge clk); n++; end
    end
    for (int k = 0; k < 3; k++) begin
      check("stall_valid_ready", {bus.o_valid, bus.o_ready}, 2'b10);
      if (k < 2) @(negedge clk);
    end
    rdy_dir = 1'b1;
    @(negedge clk);
    check("stall_release_idle", {bus.o_valid, bus.o_ready}, 2'b01);
    push_expect(8'hC3, cyc, H, 1, 0, '0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_idle();

    // Flush during the step with o_idx=1
    issue(8'h03, 2, 0, 1, D03, 0);
    wait_step(1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    check("flush_to_idle", {bus.o_ready, bus.o_step, bus.o_valid}, 3'b100);
    repeat (8) @(negedge clk);

    // Async reset mid-STEP, then the reference sequence again
    issue(8'h03, H, 1, 1, D03, 0);
    wait_step(1);
    #1 n_rst = 1'b0;
    #1 check("async_reset_outputs", out_vec(), RST_OUT);
    load_q.delete(); step_q.delete(); res_q.delete();
    #1 n_rst = 1'b1;
    issue(8'h03, H, 1, 1, D03, 0);
    wait_idle();
    repeat (3) @(negedge clk);

    // Randomised operands with random consumer back-pressure
    rnd_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      issue(W'($urandom), H, 1, 0, '0, 0);
    end
    wait_idle();
    rnd_mode = 1'b0;
    repeat (4) @(negedge clk);
    check("queues_drained", load_q.size() + step_q.size() + res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
